instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Front-end producer of program-counter values consumed by the next-PC logic. Owns the architectural PC register and issues word fetches to instruction memory over a req/ack handshake. Buffers returned instructions, each tagged with its PC, in a small FIFO toward decode. Accepts redirects carrying the resolved jump/branch target and flushes wrong-path fetches.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
DATA_W, 16, instruction width
RESET_PC, 16'h0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect  in  1  one-cycle pulse: jump or branch taken, load redirect_pc
redirect_pc  in  ADDR_W  resolved next-PC target
imem_req  out  1  fetch request, registered
imem_addr  out  ADDR_W  fetch address, registered, stable while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle (may equal req cycle)
imem_rdata  in  DATA_W  fetched instruction
if_valid  out  1  FIFO head valid
if_ready  in  1  decode accepts head
if_instr  out  DATA_W  head instruction
if_pc  out  ADDR_W  PC of head instruction
fetch_pc  out  ADDR_W  current PC register (next address to fetch)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, FIFO empty (if_valid=0, if_instr=0, if_pc=0), state IDLE, discard=0.
- FSM states: IDLE (no request outstanding), BUSY (request outstanding, data kept), DRAIN (request outstanding, data discarded).
- Credit rule: new request issued at an edge only if count_next < FIFO_DEPTH, where count_next = entries after this cycle's push/pop. The outstanding request counts as reserved, so no overflow is possible.
- IDLE -> BUSY: credit available. Set imem_req=1, imem_addr=pc.
- BUSY with imem_ack: push {imem_rdata, imem_addr}; pc <= pc+2 (mod 2^16; 0xFFFE wraps to 0x0000).
  - Credit available: stay BUSY with imem_addr=pc+2 (back-to-back, 1 instr/cycle at zero wait).
  - Otherwise: go to IDLE, imem_req=0.
- imem_req/imem_addr never change while a request is unacked.
- Redirect while IDLE: pc <= redirect_pc, FIFO flushed. Issue at next credit check.
- Redirect while BUSY without ack: flush FIFO, pc <= redirect_pc, go to DRAIN. Keep req/addr stable.
- DRAIN with ack: data dropped, no push, pc not incremented. Next request at pc (the redirect target) if credit, else IDLE.
- Redirect coinciding with ack in BUSY: ack data dropped, pc <= redirect_pc. Next request (addr=redirect_pc) same edge if credit.
- Redirect in DRAIN: pc <= latest redirect_pc, remain DRAIN.
- Redirect has priority over ack increment and over pop. A pop coinciding with a flush is ignored.
- if_valid = FIFO non-empty. Pop when if_valid & if_ready. Push and pop may occur in the same cycle.
- Latency: redirect at cycle N -> imem_req/addr=target at N+1 -> with zero-wait ack, if_valid at N+2. After reset release, first imem_req at first edge.
- redirect_pc[0] ignored (forced 0) unless feature enabled.

Optional Feature:
IFU_MISALIGN_TRAP_EN:
- Adds output misalign_fault (1 bit, reset 0).
- Redirect with redirect_pc[0]=1 sets misalign_fault (sticky until reset), flushes FIFO and stops issuing requests (outstanding request drained).
- Without the macro: no port, bit 0 forced to 0.

Decomposition:
- Package fetch_pkg: fetch_state_t (IDLE, BUSY, DRAIN), INSTR_BYTES=2, default ADDR_W/DATA_W/RESET_PC.
- Sub-module fetch_fifo: parameterised sync FIFO, width DATA_W+ADDR_W, with push, pop, flush, count.
- Top module holds FSM, PC, credit logic.

Test Plan:
- Reset release, ack every cycle req high, if_ready=1 -> imem_addr 0x0000,0x0002,0x0004..., if_pc/if_instr in order at 1 instr/cycle, first if_valid 2 cycles after release.
- if_ready=0 for 6 cycles, zero-wait memory -> exactly 2 entries buffered, imem_req drops, no addr skipped when if_ready returns.
- Ack delayed 3 cycles at addr 0x0010, redirect to 0x0100 in wait -> addr held 0x0010, data dropped (DRAIN), next req addr 0x0100, first if_pc=0x0100.
- Redirect to 0x0040 same cycle as ack for 0x0008 -> 0x0008 never appears on if_pc, next imem_addr 0x0040, FIFO flushed.
- RESET_PC=16'hFFFC, sequential fetch -> addrs 0xFFFC,0xFFFE,0x0000.
- With IFU_MISALIGN_TRAP_EN, redirect_pc=0x0031 -> misalign_fault=1 next cycle, if_valid=0, no further imem_req; without macro, next addr 0x0030.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

  // IDLE: nothing outstanding; BUSY: request outstanding and its data is kept;
  // DRAIN: request outstanding but its data belongs to a flushed path.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES  = 2;
  localparam int          DEF_ADDR_W   = 16;
  localparam int          DEF_DATA_W   = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs toward decode.
// Flush empties it in one cycle and takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop     = pop & head_valid;
  assign do_push    = push & ((count_reg < CNT_W'(DEPTH)) | do_pop);
  assign head_valid = (count_reg != '0);
  // Present zeros when empty so decode never sees stale contents.
  assign head_data  = head_valid ? mem_reg[rd_ptr_reg] : '0;
  assign count      = count_reg;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding word fetch at a
// time with credit-based flow control, and buffers results for decode.
// Optional build macro IFU_MISALIGN_TRAP_EN adds a sticky misalign_fault output;
// without it, bit 0 of a redirect target is simply cleared.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] fetch_pc
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic              misalign_fault
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              req_reg, req_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;
  logic              fifo_push;
  logic              fifo_pop;
  logic              credit;
  logic              stop_issue;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] pc_step;
  logic [DATA_W+ADDR_W-1:0] head_data;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_reg;
  logic fault_hit;

  assign fault_hit      = redirect & redirect_pc[0];
  assign stop_issue     = fault_reg | fault_hit;
  assign target_pc      = redirect_pc;
  assign misalign_fault = fault_reg;

  // Sticky fault: once a misaligned target is seen, fetching stops until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_reg <= 1'b0;
    else if (fault_hit) fault_reg <= 1'b1;
  end
`else
  assign stop_issue = 1'b0;
  assign target_pc  = redirect_pc & ~ADDR_W'(1);
`endif

  // Only data for a live (non-flushed) request is kept; redirect wins over ack and pop.
  assign fifo_push = (state_reg == BUSY) & imem_ack & ~redirect;
  assign fifo_pop  = if_valid & if_ready & ~redirect;
  assign pc_step   = pc_reg + ADDR_W'(INSTR_BYTES);

  // The next request only issues if its eventual data is guaranteed a slot.
  assign count_next = redirect ? '0 : (fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop));
  assign credit     = (count_next < CNT_W'(FIFO_DEPTH)) & ~stop_issue;

  // Next-state, next-PC and request generation.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;

    if (redirect)       pc_next = target_pc;
    else if (fifo_push) pc_next = pc_step;

    case (state_reg)
      IDLE: begin
        if (credit) begin
          req_next   = 1'b1;
          addr_next  = pc_next;
          state_next = BUSY;
        end
      end
      BUSY, DRAIN: begin
        if (imem_ack) begin
          if (credit) begin
            req_next   = 1'b1;
            addr_next  = pc_next;
            state_next = BUSY;
          end else begin
            req_next   = 1'b0;
            state_next = IDLE;
          end
        end else if (redirect) begin
          // Request stays on the bus unchanged; its data will be dropped.
          state_next = DRAIN;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State, PC and registered request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      req_reg   <= 1'b0;
      addr_reg  <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  ({imem_rdata, addr_reg}),
    .pop        (fifo_pop),
    .flush      (redirect),
    .head_valid (if_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign if_instr  = head_data[ADDR_W +: DATA_W];
  assign if_pc     = head_data[ADDR_W-1:0];
  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign fetch_pc  = pc_reg;

endmodule
